// File: rtl/inst_block_cache.sv
// Direct-mapped instruction cache returning a full block for the fetch PC.
// Misses are refilled from instruction memory with one request and a burst of
// WORD_W-wide beats delivered in word order.
// Optional build macro ICACHE_STATS_EN adds saturating hit/miss counters.
module inst_block_cache #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned BLOCK_W = 1024,
    parameter int unsigned LINES   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  in,
    output logic [BLOCK_W-1:0] out,
    output logic               hit,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_valid,
    input  logic [WORD_W-1:0]  mem_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
`endif
);

    localparam int unsigned BEATS = BLOCK_W / WORD_W;
    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam int unsigned OFF_W = $clog2(BLOCK_W / 8);
    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_W - OFF_W - IDX_W;

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e              state_q, state_d;
    logic                hit_q, hit_d;
    logic [BLOCK_W-1:0]  out_q, out_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   buf_q [BEATS];
    logic [WORD_W-1:0]   buf_d [BEATS];
    logic [BLOCK_W-1:0]  fill_line;
    logic                line_we;

    logic [BLOCK_W-1:0]  data_q  [LINES];
    logic [TAG_W-1:0]    tag_q   [LINES];
    logic [LINES-1:0]    valid_q;

    logic [IDX_W-1:0]    in_idx, fill_idx;
    logic [TAG_W-1:0]    in_tag, fill_tag;
    logic                lookup_hit;
    logic                unused_off;

    assign in_idx     = in[OFF_W +: IDX_W];
    assign in_tag     = in[ADDR_W-1 -: TAG_W];
    assign fill_idx   = addr_q[OFF_W +: IDX_W];
    assign fill_tag   = addr_q[ADDR_W-1 -: TAG_W];
    assign lookup_hit = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
    assign unused_off = ^in[OFF_W-1:0];

    // Pack the fill buffer (including a beat landing this cycle) into line layout; word 0 at MSB.
    always_comb begin
        fill_line = '0;
        for (int k = 0; k < BEATS; k++) begin
            fill_line[BLOCK_W-1-WORD_W*k -: WORD_W] = buf_d[k];
        end
    end

    // Next-state, lookup and refill sequencing.
    always_comb begin
        state_d = state_q;
        hit_d   = hit_q;
        out_d   = out_q;
        req_d   = req_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        line_we = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (lookup_hit) begin
                    hit_d = 1'b1;
                    out_d = data_q[in_idx];
                end else begin
                    hit_d   = 1'b0;
                    addr_d  = {in[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StFill;
                end
            end
            StFill: begin
                hit_d = 1'b0;
                if (mem_valid) begin
                    req_d        = 1'b0;
                    buf_d[cnt_q] = mem_data;
                    cnt_d        = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BEATS - 1)) begin
                        line_we = 1'b1;
                        state_d = StIdle;
                        // Forward the completed line when fetch still wants this block.
                        if (in[ADDR_W-1:OFF_W] == addr_q[ADDR_W-1:OFF_W]) begin
                            hit_d = 1'b1;
                            out_d = fill_line;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state register with synchronous reset; reset also invalidates all lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            hit_q   <= 1'b0;
            out_q   <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            out_q   <= out_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            if (line_we) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Data-path storage; contents are meaningless until the matching valid bit is set.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
        if (line_we) begin
            data_q[fill_idx] <= fill_line;
            tag_q[fill_idx]  <= fill_tag;
        end
    end

    assign out      = out_q;
    assign hit      = hit_q;
    assign mem_req  = req_q;
    assign mem_addr = addr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    // Saturating lookup statistics.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == StIdle) begin
            if (lookup_hit) begin
                hit_cnt_d = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_d = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + 32'd1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_inst_block_cache.sv
// Directed bench for inst_block_cache with hand-computed expected values.
module tb_inst_block_cache;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   in;
    logic [1023:0] out;
    logic          hit;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_valid;
    logic [31:0]   mem_data;
`ifdef ICACHE_STATS_EN
    logic [31:0]   hit_count;
    logic [31:0]   miss_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    inst_block_cache dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .out       (out),
        .hit       (hit),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_data  (mem_data)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] data);
        mem_valid = 1'b1;
        mem_data  = data;
        tick();
        mem_valid = 1'b0;
        mem_data  = '0;
    endtask

    // Deliver beats first..last with data base+k and `gap` idle cycles after each.
    task automatic fill(input logic [31:0] base, input int first, input int last, input int gap);
        for (int k = first; k <= last; k++) begin
            beat(base + 32'(k));
            if (k == 0) check("req_drop_after_beat0", {63'b0, mem_req}, 64'd0);
            if (k == 15) check("hit_low_mid_fill", {63'b0, hit}, 64'd0);
            for (int g = 0; g < gap; g++) tick();
        end
    endtask

    initial begin
        rst       = 1'b1;
        in        = 32'h0;
        mem_valid = 1'b0;
        mem_data  = '0;
        tick();
        tick();
        check("rst_hit", {63'b0, hit}, 64'd0);
        check("rst_req", {63'b0, mem_req}, 64'd0);
        check("rst_addr", {32'b0, mem_addr}, 64'd0);
        check("rst_out_nonzero", {63'b0, |out}, 64'd0);

        // Cold miss at block 0 with back-to-back beats.
        rst = 1'b0;
        tick();
        check("cold0_req", {63'b0, mem_req}, 64'd1);
        check("cold0_addr", {32'b0, mem_addr}, 64'd0);
        check("cold0_hit", {63'b0, hit}, 64'd0);
        fill(32'd1, 0, 31, 0);
        check("fill0_hit", {63'b0, hit}, 64'd1);
        check("fill0_w0", {32'b0, out[1023:992]}, 64'd1);
        check("fill0_w31", {32'b0, out[31:0]}, 64'd32);
        check("fill0_w1", {32'b0, out[991:960]}, 64'd2);
        tick();
        tick();
        tick();
`ifdef ICACHE_STATS_EN
        check("stats_hits", {32'b0, hit_count}, 64'd3);
        check("stats_misses", {32'b0, miss_count}, 64'd1);
`endif

        // Same block, different offset.
        in = 32'h44;
        tick();
        check("same_blk_hit", {63'b0, hit}, 64'd1);
        check("same_blk_req", {63'b0, mem_req}, 64'd0);
        check("same_blk_w0", {32'b0, out[1023:992]}, 64'd1);

        // Stray beat while idle must not disturb anything.
        beat(32'hDEAD_BEEF);
        check("stray_hit", {63'b0, hit}, 64'd1);
        check("stray_req", {63'b0, mem_req}, 64'd0);

        // Cold miss at 0x80 with 2-cycle gaps between beats.
        in = 32'h80;
        tick();
        check("gap_req", {63'b0, mem_req}, 64'd1);
        check("gap_addr", {32'b0, mem_addr}, 64'h80);
        fill(32'h100, 0, 31, 2);
        // The completing edge already raised hit; the gap ticks were idle lookups that hit.
        check("gap_hit", {63'b0, hit}, 64'd1);
        check("gap_w0", {32'b0, out[1023:992]}, 64'h100);
        check("gap_w31", {32'b0, out[31:0]}, 64'h11F);

        // Conflict: 0x400 maps to index 0 with a different tag.
        in = 32'h400;
        tick();
        check("conf_req", {63'b0, mem_req}, 64'd1);
        check("conf_addr", {32'b0, mem_addr}, 64'h400);
        fill(32'h200, 0, 31, 0);
        check("conf_hit", {63'b0, hit}, 64'd1);
        check("conf_w0", {32'b0, out[1023:992]}, 64'h200);
        in = 32'h0;
        tick();
        check("evict_req", {63'b0, mem_req}, 64'd1);
        check("evict_addr", {32'b0, mem_addr}, 64'd0);
        check("evict_hit", {63'b0, hit}, 64'd0);
        fill(32'd1, 0, 31, 0);
        check("refill0_w0", {32'b0, out[1023:992]}, 64'd1);

        // Reset in the middle of a fill at 0x100.
        in = 32'h100;
        tick();
        check("rf_addr", {32'b0, mem_addr}, 64'h100);
        fill(32'h300, 0, 10, 0);
        rst = 1'b1;
        for (int k = 11; k < 16; k++) beat(32'h300 + 32'(k));
        check("rf_rst_req", {63'b0, mem_req}, 64'd0);
        check("rf_rst_hit", {63'b0, hit}, 64'd0);
        rst = 1'b0;
        tick();
        check("rf_new_req", {63'b0, mem_req}, 64'd1);
        check("rf_new_addr", {32'b0, mem_addr}, 64'h100);
        fill(32'h400, 0, 30, 0);
        check("rf_hit_before_last", {63'b0, hit}, 64'd0);
        beat(32'h400 + 32'd31);
        check("rf_hit_done", {63'b0, hit}, 64'd1);
        check("rf_w0", {32'b0, out[1023:992]}, 64'h400);
        check("rf_w31", {32'b0, out[31:0]}, 64'h41F);

        // Reset invalidated block 0 as well.
        in = 32'h0;
        tick();
        check("post_rst_miss0", {63'b0, mem_req}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
